// File: rtl/multibyte_compare_ctrl_pkg.sv
// Shared definitions for the byte-serial multibyte magnitude comparator.
package multibyte_compare_ctrl_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Byte-index width; never narrower than one bit so WORDS=1 still has an idx register.
  function automatic int idx_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/comparator_8b.sv
// Combinational 8-bit unsigned magnitude comparator.
module comparator_8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/multibyte_compare_ctrl.sv
// Compares two WORDS-byte unsigned operands MSB first through one shared 8-bit
// comparator, stopping at the first unequal byte; start/busy/done handshake.
module multibyte_compare_ctrl
  import multibyte_compare_ctrl_pkg::*;
#(
  parameter  int WORDS = 4,
  localparam int IDX_W = idx_width(WORDS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BYTE_W*WORDS-1:0]   a_in,
  input  logic [BYTE_W*WORDS-1:0]   b_in,
  output logic                      busy,
  output logic                      done,
  output logic                      A_greater_B,
  output logic                      A_equal_B,
  output logic                      A_less_B,
  output logic [IDX_W:0]            bytes_used
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS - 1);
  localparam logic [IDX_W:0]   WORDS_V  = (IDX_W + 1)'(WORDS);

  state_t                    state;
  logic [BYTE_W*WORDS-1:0]   a_reg;
  logic [BYTE_W*WORDS-1:0]   b_reg;
  logic [IDX_W-1:0]          idx;
  logic [BYTE_W-1:0]         a_byte;
  logic [BYTE_W-1:0]         b_byte;
  logic                      cmp_gt;
  logic                      cmp_eq;
  logic                      cmp_lt;

  assign a_byte = a_reg[{idx, 3'b000} +: BYTE_W];
  assign b_byte = b_reg[{idx, 3'b000} +: BYTE_W];

  comparator_8b u_cmp (
    .a  (a_byte),
    .b  (b_byte),
    .gt (cmp_gt),
    .eq (cmp_eq),
    .lt (cmp_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      A_greater_B <= 1'b0;
      A_equal_B   <= 1'b0;
      A_less_B    <= 1'b0;
      bytes_used  <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      idx         <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg       <= a_in;
            b_reg       <= b_in;
            idx         <= IDX_LAST;
            A_greater_B <= 1'b0;
            A_equal_B   <= 1'b0;
            A_less_B    <= 1'b0;
            bytes_used  <= '0;
            busy        <= 1'b1;
            state       <= COMPARE;
          end
        end
        COMPARE: begin
          if (!cmp_eq) begin
            // First differing byte decides the whole compare.
            A_greater_B <= cmp_gt;
            A_less_B    <= cmp_lt;
            bytes_used  <= WORDS_V - {1'b0, idx};
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else if (idx == '0) begin
            A_equal_B  <= 1'b1;
            bytes_used <= WORDS_V;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_compare_ctrl.sv
// Scoreboard bench: drivers queue expected results, monitors check each done pulse.
module tb_multibyte_compare_ctrl;

  typedef struct {
    logic [2:0] flags;   // {gt, eq, lt}
    int         bytes;
    int         busy_n;
    int         gap;     // cycles since previous done; 0 = not checked
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start4 = 1'b0;
  logic [31:0] a4 = '0, b4 = '0;
  logic        busy4, done4, gt4, eq4, lt4;
  logic [2:0]  bu4;

  logic        start1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic        busy1, done1, gt1, eq1, lt1;
  logic [1:0]  bu1;

  int checks = 0;
  int passed = 0;
  exp_t q4[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  multibyte_compare_ctrl #(.WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a_in(a4), .b_in(b4),
    .busy(busy4), .done(done4), .A_greater_B(gt4), .A_equal_B(eq4),
    .A_less_B(lt4), .bytes_used(bu4)
  );

  multibyte_compare_ctrl #(.WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .A_greater_B(gt1), .A_equal_B(eq1),
    .A_less_B(lt1), .bytes_used(bu1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic exp_t mk(input logic [2:0] f, input int by, input int bn, input int gp);
    exp_t e;
    e.flags = f; e.bytes = by; e.busy_n = bn; e.gap = gp;
    return e;
  endfunction

  // Monitor for the WORDS=4 instance
  int  cyc4 = 0, last4 = 0, bcnt4 = 0;
  bit  pdone4 = 0, bad4 = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc4++;
    if (!rst_n) begin
      bcnt4 = 0; pdone4 = 0; bad4 = 0;
    end else begin
      if (pdone4) chk("w4_post_done", {30'd0, done4, busy4}, 32'd0);
      if (busy4) begin
        bcnt4++;
        if ({gt4, eq4, lt4} != 3'b000 || bu4 != 3'd0) bad4 = 1;
      end
      if (done4) begin
        if (q4.size() == 0) chk("w4_unexpected_done", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          chk("w4_flags", {29'd0, gt4, eq4, lt4}, {29'd0, e.flags});
          chk("w4_bytes_used", {29'd0, bu4}, e.bytes);
          chk("w4_busy_cycles", bcnt4, e.busy_n);
          chk("w4_flags_zero_while_busy", {31'd0, bad4}, 32'd0);
          if (e.gap != 0) chk("w4_period", cyc4 - last4, e.gap);
          $display("w4 done: flags=%b bytes_used=%0d busy_cycles=%0d", {gt4, eq4, lt4}, bu4, bcnt4);
        end
        last4 = cyc4; bcnt4 = 0; bad4 = 0;
      end
      pdone4 = done4;
    end
  end

  // Monitor for the WORDS=1 instance
  int  bcnt1 = 0;
  bit  pdone1 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bcnt1 = 0; pdone1 = 0;
    end else begin
      if (pdone1) chk("w1_post_done", {30'd0, done1, busy1}, 32'd0);
      if (busy1) bcnt1++;
      if (done1) begin
        if (q1.size() == 0) chk("w1_unexpected_done", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("w1_flags", {29'd0, gt1, eq1, lt1}, {29'd0, e.flags});
          chk("w1_bytes_used", {30'd0, bu1}, e.bytes);
          chk("w1_busy_cycles", bcnt1, e.busy_n);
          $display("w1 done: flags=%b bytes_used=%0d busy_cycles=%0d", {gt1, eq1, lt1}, bu1, bcnt1);
        end
        bcnt1 = 0;
      end
      pdone1 = done1;
    end
  end

  task automatic drain4();
    for (int i = 0; i < 60 && q4.size() != 0; i++) @(negedge clk);
    if (q4.size() != 0) begin
      chk("w4_timeout", q4.size(), 0);
      q4.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic drain1();
    for (int i = 0; i < 60 && q1.size() != 0; i++) @(negedge clk);
    if (q1.size() != 0) begin
      chk("w1_timeout", q1.size(), 0);
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run4(input logic [31:0] a, input logic [31:0] b, input exp_t e, input bit scramble);
    @(negedge clk);
    a4 = a; b4 = b; start4 = 1'b1;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
    if (scramble) begin
      a4 = 32'h0; b4 = 32'hFFFFFFFF;
    end
    drain4();
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b, input exp_t e);
    @(negedge clk);
    a1 = a; b1 = b; start1 = 1'b1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    drain1();
  endtask

  initial begin
    int  rises;
    bit  pb;
    repeat (2) @(negedge clk);
    chk("w4_reset_outputs", {26'd0, busy4, done4, gt4, eq4, lt4, bu4}, 32'd0);
    chk("w1_reset_outputs", {27'd0, busy1, done1, gt1, eq1, lt1, bu1}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run4(32'h12345678, 32'h02345678, mk(3'b100, 1, 1, 0), 0);
    run4(32'hDEADBEEF, 32'hDEADBEEF, mk(3'b010, 4, 4, 0), 0);
    run4(32'hAABBCC10, 32'hAABBCC11, mk(3'b001, 4, 4, 0), 1);
    run4(32'h80000000, 32'h7FFFFFFF, mk(3'b100, 1, 1, 0), 0);
    run4(32'hFFFF0000, 32'hFFFFFF00, mk(3'b001, 3, 3, 0), 1);

    // start held high: four back-to-back compares, five cycles apart
    @(negedge clk);
    a4 = 32'h0000FF00; b4 = 32'h0000FE00; start4 = 1'b1;
    q4.push_back(mk(3'b100, 3, 3, 0));
    for (int k = 0; k < 3; k++) q4.push_back(mk(3'b100, 3, 3, 5));
    rises = 0; pb = busy4;
    for (int i = 0; i < 60; i++) begin
      if (busy4 && !pb) rises++;
      pb = busy4;
      if (rises == 4) break;
      @(negedge clk);
    end
    start4 = 1'b0;
    chk("w4_held_accepts", rises, 4);
    drain4();

    // asynchronous reset in the second busy cycle of an equal compare
    @(negedge clk);
    a4 = 32'hDEADBEEF; b4 = 32'hDEADBEEF; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("w4_async_reset", {26'd0, busy4, done4, gt4, eq4, lt4, bu4}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("w4_abort_no_done", {31'd0, done4}, 32'd0);
    run4(32'hDEADBEEF, 32'hDEADBEEF, mk(3'b010, 4, 4, 0), 0);

    run1(8'h7F, 8'h80, mk(3'b001, 1, 1, 0));
    run1(8'h80, 8'h7F, mk(3'b100, 1, 1, 0));
    run1(8'h5A, 8'h5A, mk(3'b010, 1, 1, 0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
